// File: rtl/seg7_scan_capture.sv
// Multiplexed 7-segment bus reader: debounce, decode to BCD,
// per-digit register file with blank/illegal/select error flags.
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_valid,
  output logic                    frame_strobe,
  output logic                    err_invalid,
  output logic                    err_sel
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  logic [SW-1:0]         r_s;
  logic [CW-1:0]         r_cnt;
  logic                  r_committed;

  logic [SW-1:0]         w_new;
  logic                  w_commit;
  logic [NUM_DIGITS-1:0] w_sel;
  logic [6:0]            w_seg;
  logic [3:0]            w_code;
  logic                  w_legal;
  logic                  w_blank;
  logic                  w_onehot;
  logic                  w_multi;

  assign w_new    = {dig_sel, seg_in};
  assign w_commit = (r_cnt == CMAX) && !r_committed;
  assign w_sel    = r_s[SW-1:7];
  assign w_seg    = r_s[6:0];
  assign w_blank  = (w_seg == 7'b0000000);
  assign w_onehot = $onehot(w_sel);
  assign w_multi  = (w_sel != '0) && !w_onehot;

  always_comb begin
    w_code  = 4'hF;
    w_legal = 1'b1;
    case (w_seg)
      7'b1111110: w_code = 4'd0;
      7'b0110000: w_code = 4'd1;
      7'b1101101: w_code = 4'd2;
      7'b1111001: w_code = 4'd3;
      7'b0110011: w_code = 4'd4;
      7'b1011011: w_code = 4'd5;
      7'b1011111: w_code = 4'd6;
      7'b1110000: w_code = 4'd7;
      7'b1111111: w_code = 4'd8;
      7'b1111011: w_code = 4'd9;
      default:    w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s          <= '0;
      r_cnt        <= '0;
      r_committed  <= 1'b0;
      bcd_out      <= '1;
      digit_valid  <= '0;
      frame_valid  <= 1'b0;
      frame_strobe <= 1'b0;
      err_invalid  <= 1'b0;
      err_sel      <= 1'b0;
    end else begin
      r_s          <= w_new;
      frame_valid  <= &digit_valid;
      frame_strobe <= 1'b0;
      err_invalid  <= 1'b0;
      err_sel      <= 1'b0;
      // Commit acts on the held sample even if the bus moves this edge
      if (w_commit) begin
        r_committed <= 1'b1;
        if (w_multi) begin
          err_sel <= 1'b1;
        end else if (w_onehot) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
              if (w_blank) begin
                bcd_out[4*i +: 4] <= 4'hF;
                digit_valid[i]    <= 1'b0;
              end else if (w_legal) begin
                bcd_out[4*i +: 4] <= w_code;
                digit_valid[i]    <= 1'b1;
              end else begin
                err_invalid <= 1'b1;
              end
            end
          end
          frame_strobe <= w_sel[NUM_DIGITS-1];
        end
      end
      // A changed sample restarts debounce and re-arms the commit
      if (w_new != r_s) begin
        r_cnt       <= '0;
        r_committed <= 1'b0;
      end else if (r_cnt != CMAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: run-length debounce model for
// STABLE_CYCLES=3 and =1 builds, plus literal scenario checks.
module tb_seg7_scan_capture;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_sel = '0;

  logic [15:0] bcd0, bcd1;
  logic [3:0]  dv0, dv1;
  logic        fv0, fv1, st0, st1, ei0, ei1, es0, es1;

  always #5 clk = ~clk;

  seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
    .bcd_out(bcd0), .digit_valid(dv0), .frame_valid(fv0),
    .frame_strobe(st0), .err_invalid(ei0), .err_sel(es0)
  );

  seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
    .bcd_out(bcd1), .digit_valid(dv1), .frame_valid(fv1),
    .frame_strobe(st1), .err_invalid(ei1), .err_sel(es1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: digit table, run length of identical samples per build
  logic [6:0]  pat [10];
  logic [10:0] ms [2];
  int          mrun [2];
  logic [3:0]  mbcd [2][N];
  logic [3:0]  mdv [2];
  logic        mfv [2], mst [2], mei [2], mes [2];
  bit          mready = 0;
  logic [3:0]  old_dv, sl;
  logic [6:0]  sg;
  int          code, idx;

  function automatic int dec(input logic [6:0] p);
    int r = -1;
    for (int k = 0; k < 10; k++) if (pat[k] == p) r = k;
    return r;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        ms[m] = '0; mrun[m] = 1; mdv[m] = '0;
        mfv[m] = 0; mst[m] = 0; mei[m] = 0; mes[m] = 0;
        for (int d = 0; d < N; d++) mbcd[m][d] = 4'hF;
        mready = 1;
      end else begin
        old_dv = mdv[m];
        mst[m] = 0; mei[m] = 0; mes[m] = 0;
        if (mrun[m] == ((m == 0) ? 3 : 1)) begin
          sl = ms[m][10:7];
          sg = ms[m][6:0];
          if ($countones(sl) > 1) mes[m] = 1;
          else if ($countones(sl) == 1) begin
            idx = 0;
            for (int d = 0; d < N; d++) if (sl[d]) idx = d;
            code = dec(sg);
            if (sg == 7'd0) begin
              mbcd[m][idx] = 4'hF; mdv[m][idx] = 1'b0;
            end else if (code >= 0) begin
              mbcd[m][idx] = 4'(code); mdv[m][idx] = 1'b1;
            end else mei[m] = 1;
            mst[m] = (idx == N-1);
          end
        end
        mfv[m] = &old_dv;
        if ({dig_sel, seg_in} == ms[m]) mrun[m]++;
        else begin ms[m] = {dig_sel, seg_in}; mrun[m] = 1; end
      end
    end
  end

  function automatic logic [15:0] exp_bcd(input int m);
    logic [15:0] e;
    for (int d = 0; d < N; d++) e[4*d +: 4] = mbcd[m][d];
    return e;
  endfunction

  // Per-cycle comparison of both builds against the model
  always @(negedge clk) begin
    if (mready) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("bcd[%0d]", m), (m == 0) ? bcd0 : bcd1, exp_bcd(m));
        chk($sformatf("dv[%0d]", m), 16'((m == 0) ? dv0 : dv1),
            16'(mdv[m]));
        chk($sformatf("flags[%0d]", m),
            16'((m == 0) ? {fv0, st0, ei0, es0} : {fv1, st1, ei1, es1}),
            16'({mfv[m], mst[m], mei[m], mes[m]}));
      end
    end
  end

  int nst0 = 0, nei0 = 0, nes0 = 0, nst1 = 0;
  bit saw2 = 0;

  always @(posedge clk) begin
    #1;
    if (st0) nst0++;
    if (ei0) nei0++;
    if (es0) nes0++;
    if (st1) nst1++;
    if (bcd0[7:4] == 4'd2) saw2 = 1;
  end

  task automatic zero_cnt();
    nst0 = 0; nei0 = 0; nes0 = 0; nst1 = 0;
  endtask

  task automatic drive(input logic [3:0] s, input logic [6:0] g,
                       input int n);
    dig_sel = s;
    seg_in  = g;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101;
    pat[3] = 7'b1111001; pat[4] = 7'b0110011; pat[5] = 7'b1011011;
    pat[6] = 7'b1011111; pat[7] = 7'b1110000; pat[8] = 7'b1111111;
    pat[9] = 7'b1111011;

    repeat (2) @(negedge clk);
    chk("rst_bcd0", bcd0, 16'hFFFF);
    chk("rst_dv0", 16'(dv0), 16'h0);
    chk("rst_bcd1", bcd1, 16'hFFFF);
    rst_n = 1'b1;

    // Digit 0 = 1: latency and single commit
    zero_cnt();
    dig_sel = 4'b0001; seg_in = 7'b0110000;
    @(posedge clk); #1 chk("s1_dv1_e1", 16'(dv1), 16'h0);
    @(posedge clk); #1 chk("s1_dv1_e2", 16'(dv1), 16'h1);
    @(posedge clk); #1 chk("s1_dv0_e3", 16'(dv0), 16'h0);
    @(posedge clk); #1 chk("s1_dv0_e4", 16'(dv0), 16'h1);
    chk("s1_digit0", 16'(bcd0[3:0]), 16'h1);
    @(negedge clk);
    repeat (20) @(negedge clk);
    chk("s1_pulses", 16'(nst0 + nei0 + nes0), 16'h0);
    chk("s1_dv_hold", 16'(dv0), 16'h1);

    // Full scan 9,0,5,2 with blank gaps
    zero_cnt();
    drive(4'b1000, 7'b1111011, 3); drive(4'b0000, 7'b0, 1);
    drive(4'b0100, 7'b1111110, 3); drive(4'b0000, 7'b0, 1);
    drive(4'b0010, 7'b1011011, 3); drive(4'b0000, 7'b0, 1);
    drive(4'b0001, 7'b1101101, 3); drive(4'b0000, 7'b0, 3);
    chk("s2_bcd0", bcd0, 16'h9052);
    chk("s2_dv0", 16'(dv0), 16'hF);
    chk("s2_fv0", 16'(fv0), 16'h1);
    chk("s2_strobes", 16'(nst0), 16'h1);
    chk("s2_bcd1", bcd1, 16'h9052);

    // Glitch: short 2 then stable 3 on digit 1
    zero_cnt(); saw2 = 0;
    drive(4'b0010, 7'b1101101, 2);
    drive(4'b0010, 7'b1111001, 3);
    drive(4'b0000, 7'b0, 3);
    chk("s3_digit1", 16'(bcd0[7:4]), 16'h3);
    chk("s3_never2", 16'(saw2), 16'h0);

    // Illegal pattern, multi-hot select, blank clears digit 2
    zero_cnt();
    drive(4'b0100, 7'b1000001, 5);
    chk("s4_einv", 16'(nei0), 16'h1);
    chk("s4_digit2", 16'(bcd0[11:8]), 16'h0);
    zero_cnt();
    drive(4'b0110, 7'b1000001, 5);
    chk("s4_esel", 16'(nes0), 16'h1);
    chk("s4_esel_nowr", bcd0, 16'h9032);
    drive(4'b0100, 7'b0000000, 5);
    chk("s4_blank_bcd", bcd0, 16'h9F32);
    chk("s4_blank_dv", 16'(dv0), 16'hB);
    chk("s4_fv_drop", 16'(fv0), 16'h0);

    // Reset during debounce
    zero_cnt();
    dig_sel = 4'b0001; seg_in = 7'b0110011;
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    drive(4'b0000, 7'b0, 6);
    chk("s5_bcd0", bcd0, 16'hFFFF);
    chk("s5_dv0", 16'(dv0), 16'h0);
    chk("s5_pulses", 16'(nst0 + nei0 + nes0), 16'h0);
    chk("s5_bcd1", bcd1, 16'hFFFF);

    // Single-cycle values commit only in the STABLE_CYCLES=1 build
    zero_cnt();
    drive(4'b0001, 7'b1110000, 1);
    drive(4'b0010, 7'b1111111, 1);
    drive(4'b0100, 7'b1011111, 1);
    drive(4'b1000, 7'b0110011, 1);
    drive(4'b0000, 7'b0, 3);
    chk("s6_bcd1", bcd1, 16'h4687);
    chk("s6_dv1", 16'(dv1), 16'hF);
    chk("s6_strobe1", 16'(nst1), 16'h1);
    chk("s6_bcd0", bcd0, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
